// File: rtl/syn_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// overflow/underflow pulses and optional first-word-fall-through read port.
module syn_fifo_param #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en_i,
   input  logic [WIDTH-1:0]           data_i,
   output logic                       full_o,
   output logic                       almost_full_o,
   output logic                       overflow_o,
   input  logic                       rd_en_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       valid_o,
   output logic                       empty_o,
   output logic                       almost_empty_o,
   output logic                       underflow_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   if (WIDTH < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
       AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_param_err
      $error("syn_fifo_param: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_nxt;
   logic [CW-1:0]    count_nxt;
   logic             wr_acc;
   logic             rd_acc;
   logic             head_from_in;

   // A write into a full FIFO is allowed only when a pop frees the slot in the same cycle.
   assign rd_acc     = rd_en_i && !empty_o;
   assign wr_acc     = wr_en_i && (!full_o || rd_acc);
   assign rd_ptr_nxt = rd_ptr + {{(AW-1){1'b0}}, rd_acc};

   always_comb begin
      count_nxt = count_o;
      case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count_o + ONE_C;
         2'b01:   count_nxt = count_o - ONE_C;
         default: count_nxt = count_o;
      endcase
   end

   // In FWFT mode the new head is the word being written when nothing else remains.
   assign head_from_in = wr_acc && ((count_o == '0) || (count_o == ONE_C && rd_acc));

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= data_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count_o        <= '0;
         empty_o        <= 1'b1;
         full_o         <= 1'b0;
         almost_empty_o <= 1'b1;
         almost_full_o  <= 1'b0;
         overflow_o     <= 1'b0;
         underflow_o    <= 1'b0;
         valid_o        <= 1'b0;
         data_o         <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
         rd_ptr         <= rd_ptr_nxt;
         count_o        <= count_nxt;
         empty_o        <= (count_nxt == '0);
         full_o         <= (count_nxt == DEPTH_C);
         almost_empty_o <= (count_nxt <= AE_C);
         almost_full_o  <= (count_nxt >= AF_C);
         overflow_o     <= wr_en_i && !wr_acc;
         underflow_o    <= rd_en_i && empty_o;
         if (FWFT != 0) begin
            valid_o <= (count_nxt != '0);
            if (count_nxt != '0) data_o <= head_from_in ? data_i : mem[rd_ptr_nxt];
         end else begin
            valid_o <= rd_acc;
            if (rd_acc) data_o <= mem[rd_ptr];
         end
      end
   end

endmodule

// File: tb/tb_syn_fifo_param.sv
// Directed bench: standard-mode FIFO (u_std) and FWFT FIFO (u_fwft), both DEPTH=8.
module tb_syn_fifo_param;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       wr0 = 1'b0, rd0 = 1'b0;
   logic [7:0] din0 = '0;
   logic       full0, af0, ov0, valid0, empty0, ae0, un0;
   logic [7:0] dout0;
   logic [3:0] cnt0;

   logic       wr1 = 1'b0, rd1 = 1'b0;
   logic [7:0] din1 = '0;
   logic       full1, af1, ov1, valid1, empty1, ae1, un1;
   logic [7:0] dout1;
   logic [3:0] cnt1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   syn_fifo_param #(.WIDTH(8), .DEPTH(8), .FWFT(0)) u_std (
      .clk(clk), .rst(rst),
      .wr_en_i(wr0), .data_i(din0), .full_o(full0), .almost_full_o(af0), .overflow_o(ov0),
      .rd_en_i(rd0), .data_o(dout0), .valid_o(valid0), .empty_o(empty0),
      .almost_empty_o(ae0), .underflow_o(un0), .count_o(cnt0)
   );

   syn_fifo_param #(.WIDTH(8), .DEPTH(8), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst),
      .wr_en_i(wr1), .data_i(din1), .full_o(full1), .almost_full_o(af1), .overflow_o(ov1),
      .rd_en_i(rd1), .data_o(dout1), .valid_o(valid1), .empty_o(empty1),
      .almost_empty_o(ae1), .underflow_o(un1), .count_o(cnt1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of stimulus to the standard FIFO; outputs are sampled 1 time unit after the edge.
   task automatic step0(input logic w, input logic [7:0] d, input logic r);
      wr0 = w; din0 = d; rd0 = r;
      @(posedge clk); #1;
      wr0 = 1'b0; rd0 = 1'b0;
   endtask

   task automatic step1(input logic w, input logic [7:0] d, input logic r);
      wr1 = w; din1 = d; rd1 = r;
      @(posedge clk); #1;
      wr1 = 1'b0; rd1 = 1'b0;
   endtask

   initial begin
      // reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(cnt0), 0);
      chk("rst_empty", 32'(empty0), 1);
      chk("rst_full", 32'(full0), 0);
      chk("rst_ae", 32'(ae0), 1);
      chk("rst_af", 32'(af0), 0);
      chk("rst_valid", 32'(valid0), 0);
      chk("rst_data", 32'(dout0), 0);
      chk("rst_ov_un", 32'({ov0, un0}), 0);
      chk("rst_fwft_valid", 32'(valid1), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // fill 0..7
      for (int i = 0; i < 8; i++) begin
         step0(1'b1, 8'(i), 1'b0);
         chk("fill_count", 32'(cnt0), 32'(i + 1));
         chk("fill_af", 32'(af0), (i + 1 >= 6) ? 1 : 0);
         chk("fill_full", 32'(full0), (i == 7) ? 1 : 0);
      end
      // drain 0..7
      for (int i = 0; i < 8; i++) begin
         step0(1'b0, 8'h00, 1'b1);
         chk("drain_data", 32'(dout0), 32'(i));
         chk("drain_valid", 32'(valid0), 1);
         chk("drain_count", 32'(cnt0), 32'(7 - i));
      end
      chk("drain_empty", 32'(empty0), 1);
      step0(1'b0, 8'h00, 1'b0);
      chk("idle_valid", 32'(valid0), 0);
      chk("idle_hold", 32'(dout0), 7);

      // overflow and write+read while full
      for (int i = 0; i < 8; i++) step0(1'b1, 8'(i), 1'b0);
      step0(1'b1, 8'hAA, 1'b0);
      chk("ovf_pulse", 32'(ov0), 1);
      chk("ovf_count", 32'(cnt0), 8);
      step0(1'b0, 8'h00, 1'b0);
      chk("ovf_clear", 32'(ov0), 0);
      step0(1'b1, 8'h77, 1'b1);
      chk("fullwr_ov", 32'(ov0), 0);
      chk("fullwr_count", 32'(cnt0), 8);
      chk("fullwr_full", 32'(full0), 1);
      chk("fullwr_data", 32'(dout0), 0);
      for (int i = 1; i < 9; i++) begin
         step0(1'b0, 8'h00, 1'b1);
         chk("ovf_readback", 32'(dout0), (i == 8) ? 32'h77 : 32'(i));
      end
      chk("ovf_empty", 32'(empty0), 1);

      // underflow
      step0(1'b0, 8'h00, 1'b1);
      chk("unf_pulse", 32'(un0), 1);
      chk("unf_valid", 32'(valid0), 0);
      chk("unf_hold", 32'(dout0), 32'h77);
      step0(1'b1, 8'h5C, 1'b1);
      chk("unf_wr_pulse", 32'(un0), 1);
      chk("unf_wr_count", 32'(cnt0), 1);
      step0(1'b0, 8'h00, 1'b1);
      chk("unf_wr_data", 32'(dout0), 32'h5C);
      chk("unf_wr_valid", 32'(valid0), 1);
      chk("unf_clear", 32'(un0), 0);
      chk("unf_empty", 32'(empty0), 1);

      // pointer wrap: write 6, read 6, write 8, read 8
      for (int i = 0; i < 6; i++) begin
         step0(1'b1, 8'(8'h30 + i), 1'b0);
         chk("wrap_w6_count", 32'(cnt0), 32'(i + 1));
      end
      for (int i = 0; i < 6; i++) begin
         step0(1'b0, 8'h00, 1'b1);
         chk("wrap_r6_data", 32'(dout0), 32'(8'h30 + i));
         chk("wrap_r6_count", 32'(cnt0), 32'(5 - i));
      end
      for (int i = 0; i < 8; i++) begin
         step0(1'b1, 8'(8'h40 + i), 1'b0);
         chk("wrap_w8_count", 32'(cnt0), 32'(i + 1));
      end
      chk("wrap_full", 32'(full0), 1);
      for (int i = 0; i < 8; i++) begin
         step0(1'b0, 8'h00, 1'b1);
         chk("wrap_r8_data", 32'(dout0), 32'(8'h40 + i));
      end
      chk("wrap_empty", 32'(empty0), 1);

      // FWFT
      step1(1'b1, 8'h11, 1'b0);
      chk("fwft_first_data", 32'(dout1), 32'h11);
      chk("fwft_first_valid", 32'(valid1), 1);
      chk("fwft_first_empty", 32'(empty1), 0);
      step1(1'b1, 8'h22, 1'b0);
      chk("fwft_hold_head", 32'(dout1), 32'h11);
      chk("fwft_count2", 32'(cnt1), 2);
      step1(1'b0, 8'h00, 1'b1);
      chk("fwft_pop1_data", 32'(dout1), 32'h22);
      chk("fwft_pop1_valid", 32'(valid1), 1);
      step1(1'b0, 8'h00, 1'b1);
      chk("fwft_pop2_valid", 32'(valid1), 0);
      chk("fwft_pop2_empty", 32'(empty1), 1);
      chk("fwft_pop2_hold", 32'(dout1), 32'h22);
      step1(1'b1, 8'h33, 1'b0);
      step1(1'b1, 8'h44, 1'b1);
      chk("fwft_wrpop_data", 32'(dout1), 32'h44);
      chk("fwft_wrpop_count", 32'(cnt1), 1);

      // asynchronous reset mid-stream
      for (int i = 0; i < 5; i++) step0(1'b1, 8'(8'h60 + i), 1'b0);
      chk("pre_rst_count", 32'(cnt0), 5);
      #2 rst = 1'b1;
      #1;
      chk("arst_count", 32'(cnt0), 0);
      chk("arst_empty", 32'(empty0), 1);
      chk("arst_ae", 32'(ae0), 1);
      chk("arst_data", 32'(dout0), 0);
      chk("arst_valid", 32'(valid0), 0);
      chk("arst_fwft_valid", 32'(valid1), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      step0(1'b1, 8'h99, 1'b0);
      chk("post_rst_count", 32'(cnt0), 1);
      step0(1'b0, 8'h00, 1'b1);
      chk("post_rst_data", 32'(dout0), 32'h99);
      chk("post_rst_empty", 32'(empty0), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/syn_fifo_param.md
Name: syn_fifo_param

Overview:
Parametrised synchronous FIFO; next generation of the single-clock 8-bit FIFO used in datapath buffering. Adds configurable width and depth, occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode. Sits between producer and consumer stages in the same clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; must be a power of two, >=4
AF_LEVEL, DEPTH-2, almost_full_o asserted when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty_o asserted when count <= AE_LEVEL
FWFT, 0, 0 = standard mode (registered read, 1-cycle latency); 1 = first-word-fall-through

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
wr_en_i  in  1  write request
data_i  in  WIDTH  write data
full_o  out  1  FIFO holds DEPTH entries
almost_full_o  out  1  count >= AF_LEVEL
overflow_o  out  1  one-cycle pulse: write requested while full and not accepted
rd_en_i  in  1  read request / pop
data_o  out  WIDTH  read data
valid_o  out  1  data_o holds a valid word (see Behaviour)
empty_o  out  1  FIFO holds 0 entries
almost_empty_o  out  1  count <= AE_LEVEL
underflow_o  out  1  one-cycle pulse: read requested while empty
count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (async assert, sync release on next edge): wr/rd pointers 0, count_o 0, empty_o 1, full_o 0, almost_empty_o 1, almost_full_o 0, overflow_o 0, underflow_o 0, valid_o 0, data_o 0. Storage array not reset. Reset mid-operation discards all contents.
- Pointers $clog2(DEPTH) bits, wrap naturally from DEPTH-1 to 0. Occupancy held in a registered counter; all flags registered and derived from next-state count (no combinational path from enables to flags).
- Write accepted when wr_en_i && (!full_o || read accepted same cycle). Accepted write stores data_i at wr pointer, increments pointer.
- Read accepted when rd_en_i && !empty_o. Accepted read advances rd pointer.
- Count: +1 write only, -1 read only, unchanged when both accepted or neither.
- Full and wr_en_i && rd_en_i: both accepted, count stays DEPTH, full_o stays 1, no overflow.
- Empty and wr_en_i && rd_en_i: write accepted, read rejected, underflow_o pulses, count becomes 1. No write-to-read bypass.
- overflow_o / underflow_o: asserted the cycle after the offending request, for exactly one cycle per offending cycle; non-sticky.
- Standard mode (FWFT=0): on accepted read, data_o loads head word at next edge and valid_o=1 for that one cycle; otherwise valid_o=0 and data_o holds last value.
- FWFT mode (FWFT=1): data_o continuously presents head word whenever !empty_o; valid_o = !empty_o. rd_en_i pops; next word (if any) appears the cycle after the pop. When empty, data_o holds last value. First write into empty FIFO is visible on data_o with valid_o=1 the cycle after the write edge.
- Thresholds: AF_LEVEL in 1..DEPTH, AE_LEVEL in 0..DEPTH-1; out-of-range values are illegal (elaboration check).

Test Plan:
- WIDTH=8, DEPTH=8, FWFT=0: reset, write 0..7 on 8 consecutive cycles -> full_o=1 after 8th edge, count_o=8, almost_full_o=1 from count 6; then read 8 cycles -> data_o 0..7 each one cycle after rd_en, valid_o pulse per read, empty_o=1 at end.
- Full FIFO, write 0xAA with rd_en_i=0 -> overflow_o one-cycle pulse, count_o stays 8, later reads never return 0xAA; then wr+rd same cycle -> no overflow, count_o 8, written word returned last.
- Empty FIFO, rd_en_i=1 -> underflow_o one-cycle pulse, valid_o=0, data_o unchanged; simultaneous wr 0x5C + rd on empty -> count_o=1, underflow_o pulse, next read returns 0x5C.
- FWFT=1, DEPTH=8: write 0x11,0x22 -> data_o=0x11, valid_o=1 one cycle after first write; pop -> data_o=0x22 next cycle; pop -> valid_o=0, empty_o=1.
- Wrap: write 6, read 6, write 8 -> full_o=1, readback in order across pointer wrap, count_o tracks 0..8 correctly.
- Assert rst mid-stream with count_o=5 -> all outputs return to reset values immediately (async), empty_o=1; subsequent write/read returns new data only.
